alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that produces the operand pair and ALU select code consumed by the RV32I ALU.
- Decodes RV32I integer instructions, forms operand A and operand B (register or immediate), and maps opcode/funct3/funct7 to the 4-bit ALU select code.
- Registers the result in a 2-entry skid-buffered ID/EX stage with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of the instruction.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- flush  in  1  synchronous kill of all buffered entries.
- out_valid  out  1  output entry valid.
- out_ready  in  1  ALU/EX stage accepts the entry.
- out_a  out  32  ALU operand a.
- out_b  out  32  ALU operand b.
- out_alusel  out  4  ALU select code: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sar 7, or 8, and 9, nop 15.
- out_rd  out  5  destination register index.
- out_rd_we  out  1  writeback enable.
- out_illegal  out  1  unsupported or malformed instruction.
- out_pc  out  32  PC passed through.

Behaviour:
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - Accept-to-out_valid latency is 1 cycle when the stage is empty.
- State machine (FSM) states: EMPTY, ONE (main register valid), TWO (main and skid registers valid).
  - in_ready = (state != TWO), decoded from registered state only. It has no combinational path from out_ready.
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> TWO; the new entry goes to the skid register.
  - ONE + drain, no accept -> EMPTY.
  - ONE + accept + drain -> ONE; the main register loads the new entry.
  - TWO + drain -> ONE; the skid entry moves to main. No accept is possible in TWO.
- Ordering: entries leave in arrival order. Output fields never change while out_valid=1 and out_ready=0.
- flush:
  - Next state is EMPTY and out_valid=0 next cycle.
  - A same-cycle input is dropped; a same-cycle output transfer still counts as delivered.
  - Flush has priority over accept.
- Reset (asynchronous):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_a, out_b, out_pc, out_rd all zero; out_alusel=15; out_rd_we=0; out_illegal=0.
  - Reset mid-transfer discards all entries.
- Decode, opcode = instr[6:0]:
  - OP 0110011: a=rs1, b=rs2.
    - funct3 0: add, or sub when funct7=0100000.
    - funct3 1 sll, 2 slt, 3 sltu, 4 xor.
    - funct3 5: srl, or sar when funct7=0100000.
    - funct3 6 or, 7 and.
    - funct7 must be 0000000, or 0100000 only with funct3 0 or 5; otherwise illegal.
  - OP-IMM 0010011: a=rs1, b=sign-extended instr[31:20].
    - funct3 mapping as OP, with no sub.
    - Shifts (funct3 1/5): b={27'b0,instr[24:20]}.
    - instr[31:25] must be 0000000, or 0100000 only for srai; otherwise illegal.
  - LUI 0110111: a=0, b={instr[31:12],12'b0}, add.
  - AUIPC 0010111: a=pc, b={instr[31:12],12'b0}, add.
  - Any other opcode: illegal.
- For illegal instructions: alusel=15, a=b=0, rd_we=0, out_illegal=1. The entry still flows through the pipeline.
- out_rd=instr[11:7]. out_rd_we=1 for legal instructions with rd!=0, else 0.

Test Plan:
- Reset release, idle: out_valid=0, in_ready=1, out_alusel=15.
- Decode:
  - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, alusel=0, rd=3, rd_we=1.
  - sub x5,x6,x7 (0x407302B3) -> alusel=1, rd=5.
  - addi x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, alusel=0.
  - srai x2,x1,4 (0x4040D113) -> b=4, alusel=7.
  - lui x4,0x12345 (0x12345237) -> a=0, b=0x12345000.
  - opcode 0x7F -> out_illegal=1, alusel=15, rd_we=0.
- Backpressure:
  - out_ready=0; push I0 and I1 -> in_ready=0 and out fields hold I0.
  - out_ready=1 -> I0 then I1 delivered on consecutive cycles; in_ready rises after the first drain.
- Stream: in_valid=1 and out_ready=1 for 8 cycles -> 8 transfers at 1 per cycle, order preserved.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
- Async reset asserted mid-cycle while in ONE -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: forms ALU operands and select code, then buffers the result
// in a two-entry skid-buffered ID/EX register with valid/ready handshakes.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alusel,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [3:0] SelAdd  = 4'd0;
  localparam logic [3:0] SelSub  = 4'd1;
  localparam logic [3:0] SelSll  = 4'd2;
  localparam logic [3:0] SelSlt  = 4'd3;
  localparam logic [3:0] SelSltu = 4'd4;
  localparam logic [3:0] SelXor  = 4'd5;
  localparam logic [3:0] SelSrl  = 4'd6;
  localparam logic [3:0] SelSar  = 4'd7;
  localparam logic [3:0] SelOr   = 4'd8;
  localparam logic [3:0] SelAnd  = 4'd9;
  localparam logic [3:0] SelNop  = 4'd15;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      alusel;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q;
  entry_t main_q, skid_q, dec;

  // alt selects sub (funct3 0) or arithmetic shift (funct3 5)
  function automatic logic [3:0] f3_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] sel;
    case (f3)
      3'd0:    sel = alt ? SelSub : SelAdd;
      3'd1:    sel = SelSll;
      3'd2:    sel = SelSlt;
      3'd3:    sel = SelSltu;
      3'd4:    sel = SelXor;
      3'd5:    sel = alt ? SelSar : SelSrl;
      3'd6:    sel = SelOr;
      default: sel = SelAnd;
    endcase
    return sel;
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

  always_comb begin
    dec         = '0;
    dec.alusel  = SelNop;
    dec.illegal = 1'b1;
    dec.rd      = in_instr[11:7];
    dec.pc      = in_pc;
    case (opcode)
      OpcOp: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          dec.illegal = 1'b0;
          dec.a       = in_rs1_data;
          dec.b       = in_rs2_data;
          dec.alusel  = f3_sel(funct3, funct7[5]);
        end
      end
      OpcOpImm: begin
        // funct7 field only constrains shifts; other OP-IMM forms use it as immediate
        if (!is_shift || funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && funct3 == 3'd5)) begin
          dec.illegal = 1'b0;
          dec.a       = in_rs1_data;
          dec.b       = is_shift ? {27'b0, in_instr[24:20]}
                                 : {{20{in_instr[31]}}, in_instr[31:20]};
          dec.alusel  = f3_sel(funct3, funct7[5] && (funct3 == 3'd5));
        end
      end
      OpcLui: begin
        dec.illegal = 1'b0;
        dec.b       = {in_instr[31:12], 12'b0};
        dec.alusel  = SelAdd;
      end
      OpcAuipc: begin
        dec.illegal = 1'b0;
        dec.a       = in_pc;
        dec.b       = {in_instr[31:12], 12'b0};
        dec.alusel  = SelAdd;
      end
      default: ;
    endcase
    dec.rd_we = !dec.illegal && (dec.rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StEmpty;
      main_q         <= '0;
      main_q.alusel  <= SelNop;
      skid_q         <= '0;
      skid_q.alusel  <= SelNop;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_valid) begin
            main_q  <= dec;
            state_q <= StOne;
          end
        end
        StOne: begin
          case ({in_valid, out_ready})
            2'b10: begin
              skid_q  <= dec;
              state_q <= StTwo;
            end
            2'b01: state_q <= StEmpty;
            2'b11: main_q  <= dec;
            default: ;
          endcase
        end
        StTwo: begin
          if (out_ready) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign in_ready    = (state_q != StTwo);
  assign out_valid   = (state_q != StEmpty);
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_alusel  = main_q.alusel;
  assign out_rd      = main_q.rd;
  assign out_rd_we   = main_q.rd_we;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode/handshake cases plus random traffic,
// checked by a queue-based scoreboard fed from an instruction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [31:0] out_a, out_b, out_pc;
  logic [3:0]  out_alusel;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alusel  (out_alusel),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the ALU should be asked to do for each instruction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   sel_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic shift = (f3 == 3'd1) || (f3 == 3'd5);
    e = '{a: 32'd0, b: 32'd0, sel: 4'd15, rd: ins[11:7], we: 1'b0, ill: 1'b1, pc: pc};
    case (ins[6:0])
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 1'b0; e.a = r1; e.b = r2;
        e.sel = 4'(sel_tab[f3]);
        if (f7 == 7'h20) e.sel = (f3 == 3'd0) ? 4'd1 : 4'd7;
      end
      7'h13: if (!shift || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) begin
        e.ill = 1'b0; e.a = r1;
        e.b = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
        e.sel = 4'(sel_tab[f3]);
        if (shift && f7 == 7'h20) e.sel = 4'd7;
      end
      7'h37: begin e.ill = 1'b0; e.b = ins & 32'hFFFFF000; e.sel = 4'd0; end
      7'h17: begin e.ill = 1'b0; e.a = pc; e.b = ins & 32'hFFFFF000; e.sel = 4'd0; end
      default: ;
    endcase
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [6:0] pick_f7();
    int k = $urandom_range(4);
    if (k < 2) return 7'h00;
    if (k < 4) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(5))
      0: return {pick_f7(), r[24:7], 7'h33};
      1, 2: begin
        if (r[14:12] == 3'd1 || r[14:12] == 3'd5) return {pick_f7(), r[24:7], 7'h13};
        return {r[31:7], 7'h13};
      end
      3: return {r[31:7], 7'h37};
      4: return {r[31:7], 7'h17};
      default: return r;
    endcase
  endfunction

  // Monitor: the presented entry must always be the oldest outstanding one
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("out_valid_with_nothing_outstanding", 128'(out_valid), 128'(0));
      end else begin
        chk("entry", 128'({out_a, out_b, out_alusel, out_rd, out_rd_we, out_illegal, out_pc}),
            128'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; called and returns at posedge+1
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
    logic [31:0] r1 = $urandom;
    logic [31:0] r2 = $urandom;
    in_valid = v; in_instr = ins; in_pc = pc_ctr;
    in_rs1_data = r1; in_rs2_data = r2; flush = fl; out_ready = ordy;
    @(negedge clk); #1;
    if (fl) q.delete();
    else if (v && in_ready) q.push_back(model(ins, pc_ctr, r1, r2));
    @(posedge clk); #1;
    pc_ctr += 4;
  endtask

  task automatic step_ops(input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2);
    in_valid = 1'b1; in_instr = ins; in_pc = pc_ctr;
    in_rs1_data = r1; in_rs2_data = r2; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    if (in_ready) q.push_back(model(ins, pc_ctr, r1, r2));
    @(posedge clk); #1;
    pc_ctr += 4;
  endtask

  initial begin
    logic [31:0] p0, p1;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_alusel", 128'(out_alusel), 128'(15));
    chk("rst_fields", 128'({out_a, out_b, out_pc, out_rd, out_rd_we, out_illegal}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    step_ops(32'h002081B3, 32'd5, 32'd7);
    chk("add_valid", 128'(out_valid), 128'(1));
    chk("add_ops", 128'({out_a, out_b}), 128'({32'd5, 32'd7}));
    chk("add_sel_rd_we", 128'({out_alusel, out_rd, out_rd_we}), 128'({4'd0, 5'd3, 1'b1}));
    step(1'b1, 32'h407302B3, 1'b0, 1'b1);
    chk("sub_sel_rd", 128'({out_alusel, out_rd}), 128'({4'd1, 5'd5}));
    step(1'b1, 32'hFFF00093, 1'b0, 1'b1);
    chk("addi_b_sel", 128'({out_b, out_alusel}), 128'({32'hFFFFFFFF, 4'd0}));
    step(1'b1, 32'h4040D113, 1'b0, 1'b1);
    chk("srai_b_sel", 128'({out_b, out_alusel}), 128'({32'd4, 4'd7}));
    step(1'b1, 32'h12345237, 1'b0, 1'b1);
    chk("lui_ab", 128'({out_a, out_b}), 128'({32'd0, 32'h12345000}));
    step(1'b1, 32'h00000FFF, 1'b0, 1'b1);
    chk("illegal_flags", 128'({out_illegal, out_alusel, out_rd_we}), 128'({1'b1, 4'd15, 1'b0}));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Backpressure
    p0 = pc_ctr;
    step(1'b1, 32'h002081B3, 1'b0, 1'b0);
    p1 = pc_ctr;
    step(1'b1, 32'h00110113, 1'b0, 1'b0);
    chk("bp_in_ready_full", 128'(in_ready), 128'(0));
    chk("bp_hold_i0", 128'(out_pc), 128'(p0));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_still_i0", 128'({out_pc, in_ready}), 128'({p0, 1'b0}));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bp_after_drain", 128'({out_pc, in_ready, out_valid}), 128'({p1, 1'b1, 1'b1}));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bp_empty", 128'(out_valid), 128'(0));

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      step(1'b1, rand_instr(), 1'b0, 1'b1);
      chk("stream_rate", 128'({out_valid, in_ready}), 128'({1'b1, 1'b1}));
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stream_drained", 128'(q.size()), 128'(0));

    // Flush while full with a same-cycle input
    step(1'b1, 32'h002081B3, 1'b0, 1'b0);
    step(1'b1, 32'h407302B3, 1'b0, 1'b0);
    step(1'b1, 32'h12345237, 1'b1, 1'b0);
    chk("flush_state", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_nothing_appears", 128'(out_valid), 128'(0));

    // Asynchronous reset while holding one entry
    step(1'b1, 32'h002081B3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'({out_valid, in_ready, out_alusel}), 128'({1'b0, 1'b1, 4'd15}));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, rand_instr(), $urandom_range(24) == 0,
           $urandom_range(2) != 0);
    end
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !out_valid) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("final_drain", 128'({q.size(), out_valid}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
